// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and busy-bit scoreboard feeding the register file's single write port.
// Define RF_WB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over EXU.
module rf_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  raw_hazard,
   input  logic                  exu_valid,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   output logic                  exu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  exu_grant, lsu_grant;
   logic [ADDR_WIDTH-1:0] win_rd;
   logic [DATA_WIDTH-1:0] win_data;

`ifdef RF_WB_RR_EN
   // Pointer: 0 favours EXU, 1 favours LSU on contention
   logic ptr_q, ptr_d;

   always_comb begin
      exu_grant = exu_valid && (!lsu_valid || !ptr_q);
      lsu_grant = lsu_valid && (!exu_valid || ptr_q);
      ptr_d     = ptr_q;
      if (exu_grant) begin
         ptr_d = 1'b1;
      end else if (lsu_grant) begin
         ptr_d = 1'b0;
      end
   end
`else
   always_comb begin
      lsu_grant = lsu_valid;
      exu_grant = exu_valid && !lsu_valid;
   end
`endif

   assign exu_ready  = exu_grant;
   assign lsu_ready  = lsu_grant;
   assign iss_ready  = !busy_q[iss_rd];
   assign raw_hazard = busy_q[rs1_addr] | busy_q[rs2_addr];

   always_comb begin
      win_rd   = lsu_grant ? lsu_rd   : exu_rd;
      win_data = lsu_grant ? lsu_data : exu_data;
   end

   // The output stage drains every cycle; addr/data hold when nothing is granted
   always_comb begin
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (exu_grant || lsu_grant) begin
         rf_wen_d   = (win_rd != '0);
         rf_waddr_d = win_rd;
         rf_wdata_d = win_data;
      end
   end

   // Clear happens on the same edge the register file captures; a same-index set wins
   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
`ifdef RF_WB_RR_EN
         ptr_q      <= 1'b0;
`endif
      end else begin
         busy_q     <= busy_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
`ifdef RF_WB_RR_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expectations follow RF_WB_RR_EN when defined.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        raw_hazard;
   logic        exu_valid;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        exu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checkCount = 0;
   int errorCount = 0;

   rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .raw_hazard(raw_hazard),
      .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the edge
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
      exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
   endtask

   task automatic doReset();
      idleInputs();
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [31:0] writtenMask;
      int          wenRun;
      logic        expExu;

      doReset();
      iss_rd = 5'd7;
      #1;
      checkOutput("rst_wen", rf_wen, 0);
      checkOutput("rst_waddr", rf_waddr, 0);
      checkOutput("rst_wdata", rf_wdata, 0);
      checkOutput("rst_iss_ready", iss_ready, 1);
      checkOutput("rst_raw", raw_hazard, 0);
      checkOutput("rst_exu_ready", exu_ready, 0);
      checkOutput("rst_lsu_ready", lsu_ready, 0);

      // Single EXU write to rd 5
      exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
      #1;
      checkOutput("w5_exu_ready", exu_ready, 1);
      checkOutput("w5_lsu_ready", lsu_ready, 0);
      applyStimulus();
      exu_valid = 1'b0;
      checkOutput("w5_wen", rf_wen, 1);
      checkOutput("w5_waddr", rf_waddr, 5);
      checkOutput("w5_wdata", rf_wdata, 32'hDEADBEEF);
      applyStimulus();
      checkOutput("w5_wen_after", rf_wen, 0);
      checkOutput("w5_waddr_hold", rf_waddr, 5);

      // Issue rd 7, LSU writes it back, hazard clears two cycles after grant
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      checkOutput("i7_ready", iss_ready, 1);
      applyStimulus();
      iss_valid = 1'b0; rs1_addr = 5'd7;
      #1;
      checkOutput("i7_raw", raw_hazard, 1);
      checkOutput("i7_waw", iss_ready, 0);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
      #1;
      checkOutput("l7_lsu_ready", lsu_ready, 1);
      applyStimulus();
      lsu_valid = 1'b0;
      checkOutput("l7_wen", rf_wen, 1);
      checkOutput("l7_waddr", rf_waddr, 7);
      checkOutput("l7_raw_n1", raw_hazard, 1);
      checkOutput("l7_waw_n1", iss_ready, 0);
      applyStimulus();
      checkOutput("l7_raw_n2", raw_hazard, 0);
      checkOutput("l7_iss_ready_n2", iss_ready, 1);
      iss_valid = 1'b1;
      applyStimulus();
      iss_valid = 1'b0;
      #1;
      checkOutput("i7_reissue_raw", raw_hazard, 1);

      // Write to rd 0 is accepted but never enables the port
      exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234;
      #1;
      checkOutput("w0_exu_ready", exu_ready, 1);
      applyStimulus();
      exu_valid = 1'b0;
      checkOutput("w0_wen", rf_wen, 0);
      checkOutput("w0_wdata", rf_wdata, 32'h1234);
      iss_valid = 1'b1; iss_rd = 5'd0;
      #1;
      checkOutput("i0_ready", iss_ready, 1);
      applyStimulus();
      iss_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      checkOutput("i0_raw", raw_hazard, 0);
      checkOutput("i0_ready_after", iss_ready, 1);

      // Contention for 4 cycles from a fresh reset
      doReset();
      exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA;
      lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB;
      for (int c = 0; c < 4; c++) begin
`ifdef RF_WB_RR_EN
         expExu = ((c % 2) == 0);
`else
         expExu = 1'b0;
`endif
         #1;
         checkOutput($sformatf("arb%0d_exu", c), exu_ready, expExu);
         checkOutput($sformatf("arb%0d_lsu", c), lsu_ready, !expExu);
         applyStimulus();
         checkOutput($sformatf("arb%0d_waddr", c), rf_waddr, expExu ? 10 : 11);
      end
      idleInputs();

      // Reset lands on the cycle after a grant to rd 3
      iss_valid = 1'b1; iss_rd = 5'd3;
      applyStimulus();
      iss_valid = 1'b0;
      exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
      applyStimulus();
      exu_valid = 1'b0;
      checkOutput("r3_wen_pending", rf_wen, 1);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0; rs1_addr = 5'd3; iss_rd = 5'd3;
      #1;
      checkOutput("r3_wen_killed", rf_wen, 0);
      checkOutput("r3_waddr", rf_waddr, 0);
      checkOutput("r3_raw", raw_hazard, 0);
      checkOutput("r3_iss_ready", iss_ready, 1);

      // Back-to-back EXU writes rd 1..31
      writtenMask = '0;
      wenRun = 0;
      for (int i = 1; i < 32; i++) begin
         exu_valid = 1'b1; exu_rd = 5'(i); exu_data = 32'h100 + 32'(i);
         #1;
         checkOutput($sformatf("bb%0d_ready", i), exu_ready, 1);
         applyStimulus();
         if (rf_wen) begin
            wenRun++;
            writtenMask[rf_waddr] = 1'b1;
         end
         checkOutput($sformatf("bb%0d_waddr", i), rf_waddr, 32'(i));
         checkOutput($sformatf("bb%0d_wdata", i), rf_wdata, 32'h100 + 32'(i));
      end
      exu_valid = 1'b0;
      applyStimulus();
      checkOutput("bb_run", wenRun, 31);
      checkOutput("bb_mask", writtenMask, 32'hFFFF_FFFE);
      checkOutput("bb_wen_end", rf_wen, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
